// File: rtl/pixel_point_mac_engine.sv
// pixel_point_mac_engine
//
// Streams two signed operand vectors from a dual-read-port memory (A at base_addrA+i,
// B at base_addrB+i), accumulates their products at full precision, then applies an
// arithmetic right shift, an optional ReLU and signed saturation. The finished pixel is
// held on out_pix with done=1 until the consumer acks.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    start request, sampled only in IDLE
//   ack                   result acknowledge, sampled only in DONE
//   base_addrA/B          operand vector start addresses (captured on start)
//   length                number of products to accumulate (captured on start)
//   shift, relu_en        post-scale controls (captured on start)
//   mem_rd_en             read strobe shared by both ports
//   mem_addrA/B           read addresses, wrap modulo 2^ADDR_W
//   mem_dataA/B           read data, valid RD_LAT cycles after the strobe
//   out_pix, done         result pixel and its valid flag
//   busy                  high whenever the engine is not idle
module pixel_point_mac_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned ACC_W  = 42,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ack,
  input  logic [ADDR_W-1:0] base_addrA,
  input  logic [ADDR_W-1:0] base_addrB,
  input  logic [LEN_W-1:0]  length,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addrA,
  output logic [ADDR_W-1:0] mem_addrB,
  input  logic [DATA_W-1:0] mem_dataA,
  input  logic [DATA_W-1:0] mem_dataB,
  output logic [OUT_W-1:0]  out_pix,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                   state;
  logic [LEN_W-1:0]         len_r;
  logic [LEN_W-1:0]         issued;
  logic [4:0]               shift_r;
  logic                     relu_r;
  logic [RD_LAT-1:0]        vld;     // delayed copies of mem_rd_en; MSB marks valid read data
  logic signed [ACC_W-1:0]  acc;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [ACC_W-1:0]    clamped;
  logic [ACC_W-OUT_W:0]       upper;   // bits that must all equal the sign bit to fit OUT_W
  logic [OUT_W-1:0]           result;

  // Product and finalisation datapath.
  always_comb begin
    prod     = $signed(mem_dataA) * $signed(mem_dataB);
    prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    shifted  = acc >>> shift_r;
    clamped  = (relu_r && shifted[ACC_W-1]) ? '0 : shifted;
    upper    = clamped[ACC_W-1:OUT_W-1];
    if ((&upper) || !(|upper)) begin
      result = clamped[OUT_W-1:0];
    end else if (clamped[ACC_W-1]) begin
      result = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      out_pix   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addrA <= '0;
      mem_addrB <= '0;
      len_r     <= '0;
      issued    <= '0;
      shift_r   <= '0;
      relu_r    <= 1'b0;
      vld       <= '0;
      acc       <= '0;
    end else begin
      vld <= RD_LAT'({vld, mem_rd_en});
      if (vld[RD_LAT-1]) begin
        acc <= acc + prod_ext;
      end

      case (state)
        StIdle: begin
          if (en) begin
            busy      <= 1'b1;
            len_r     <= length;
            shift_r   <= shift;
            relu_r    <= relu_en;
            acc       <= '0;
            mem_addrA <= base_addrA;
            mem_addrB <= base_addrB;
            issued    <= LEN_W'(1);
            if (length != '0) begin
              mem_rd_en <= 1'b1;
              state     <= StFetch;
            end else begin
              // Zero-length runs through one empty drain cycle so the result path is shared.
              state <= StDrain;
            end
          end
        end

        StFetch: begin
          if (issued == len_r) begin
            mem_rd_en <= 1'b0;
            state     <= StDrain;
          end else begin
            mem_addrA <= mem_addrA + ADDR_W'(1);
            mem_addrB <= mem_addrB + ADDR_W'(1);
            issued    <= issued + LEN_W'(1);
          end
        end

        StDrain: begin
          // Pipeline empty means the last product has already landed in acc.
          if (vld == '0) begin
            out_pix <= result;
            done    <= 1'b1;
            state   <= StDone;
          end
        end

        StDone: begin
          if (ack) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_point_mac_engine.sv
module tb_pixel_point_mac_engine;

  localparam int unsigned RD_LAT = 1;
  localparam int          MEM    = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ack = 1'b0;
  logic [13:0] base_addrA = '0;
  logic [13:0] base_addrB = '0;
  logic [9:0]  length = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        mem_rd_en;
  logic [13:0] mem_addrA;
  logic [13:0] mem_addrB;
  logic [15:0] mem_dataA;
  logic [15:0] mem_dataB;
  logic [31:0] out_pix;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [15:0] mem [MEM];
  logic [15:0] pipe_a [RD_LAT];
  logic [15:0] pipe_b [RD_LAT];

  always #5 clk = ~clk;

  pixel_point_mac_engine #(
    .DATA_W(16), .ADDR_W(14), .LEN_W(10), .ACC_W(42), .OUT_W(32), .RD_LAT(RD_LAT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ack        (ack),
    .base_addrA (base_addrA),
    .base_addrB (base_addrB),
    .length     (length),
    .shift      (shift),
    .relu_en    (relu_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addrA  (mem_addrA),
    .mem_addrB  (mem_addrB),
    .mem_dataA  (mem_dataA),
    .mem_dataB  (mem_dataB),
    .out_pix    (out_pix),
    .done       (done),
    .busy       (busy)
  );

  // Memory with RD_LAT-cycle read latency; garbage appears when no read was issued.
  always @(posedge clk) begin
    pipe_a[0] <= mem_rd_en ? mem[mem_addrA] : 16'($urandom);
    pipe_b[0] <= mem_rd_en ? mem[mem_addrB] : 16'($urandom);
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign mem_dataA = pipe_a[RD_LAT-1];
  assign mem_dataB = pipe_b[RD_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain dot product, shift, ReLU, clamp to 32-bit signed.
  function automatic longint model(input int ba, input int bb, input int len, input int sh,
                                   input bit relu);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      acc += longint'(mem[(ba + i) % MEM]) * longint'(mem[(bb + i) % MEM]);
    end
    r = acc >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r;
  endfunction

  task automatic run_op(input int ba, input int bb, input int len, input int sh, input bit relu,
                        input bit hold_en, input int rst_at);
    longint      exp_r;
    logic [31:0] exp_pix;
    int          exp_c;
    int          nrd;
    int          c;
    bit          seen;
    exp_r   = model(ba, bb, len, sh, relu);
    exp_pix = exp_r[31:0];
    exp_c   = (len == 0) ? 1 : len + int'(RD_LAT) + 1;

    @(negedge clk);
    base_addrA = 14'(ba);
    base_addrB = 14'(bb);
    length     = 10'(len);
    shift      = 5'(sh);
    relu_en    = relu;
    en         = 1'b1;
    @(negedge clk);  // capture edge E0 has passed
    if (!hold_en) en = 1'b0;
    // Inputs changed after capture must be ignored.
    base_addrA = 14'($urandom);
    base_addrB = 14'($urandom);
    length     = 10'($urandom);
    shift      = 5'($urandom);
    relu_en    = 1'($urandom);
    check_eq("busy_run", 64'(busy), 64'(1));

    nrd  = 0;
    c    = 0;
    seen = 1'b0;
    while (!seen && c <= exp_c + 20) begin
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_pix", 64'(out_pix), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("rst_addrA", 64'(mem_addrA), 64'(0));
        check_eq("rst_addrB", 64'(mem_addrB), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        return;
      end
      if (mem_rd_en) begin
        check_eq("addrA", 64'(mem_addrA), 64'((ba + nrd) % MEM));
        check_eq("addrB", 64'(mem_addrB), 64'((bb + nrd) % MEM));
        nrd++;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 64'(0), 64'(1));
    end else begin
      check_eq("latency", 64'(c), 64'(exp_c));
    end
    check_eq("rd_count", 64'(nrd), 64'(len));
    check_eq("pix", 64'(out_pix), 64'(exp_pix));

    repeat (5) begin
      @(negedge clk);
      check_eq("hold_done", 64'(done), 64'(1));
      check_eq("hold_pix", 64'(out_pix), 64'(exp_pix));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_eq("ack_done", 64'(done), 64'(0));
    check_eq("ack_busy", 64'(busy), 64'(0));
    check_eq("ack_pix_kept", 64'(out_pix), 64'(exp_pix));
    en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM; i++) mem[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    check_eq("reset_pix", 64'(out_pix), 64'(0));
    check_eq("reset_done", 64'(done), 64'(0));
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_rd_en", 64'(mem_rd_en), 64'(0));
    check_eq("reset_addrA", 64'(mem_addrA), 64'(0));
    check_eq("reset_addrB", 64'(mem_addrB), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem[i]        = 16'(i + 1);
      mem[6912 + i] = 16'(i + 5);
      mem[300 + i]  = 16'sh8000;
      mem[400 + i]  = 16'sh7fff;
    end
    mem[100] = -16'sd3;
    mem[101] = -16'sd4;
    mem[200] = 16'sd5;
    mem[201] = 16'sd6;

    run_op(0, 6912, 4, 0, 1'b0, 1'b0, -1);      // 70
    run_op(100, 200, 2, 0, 1'b0, 1'b0, -1);     // -39
    run_op(100, 200, 2, 0, 1'b1, 1'b0, -1);     // ReLU -> 0
    run_op(0, 6912, 4, 2, 1'b0, 1'b0, -1);      // 70 >>> 2 = 17
    run_op(300, 300, 4, 0, 1'b0, 1'b0, -1);     // 2^32 -> 0x7FFFFFFF
    run_op(400, 300, 4, 0, 1'b0, 1'b0, -1);     // -> 0x80000000
    run_op(0, 6912, 0, 0, 1'b0, 1'b0, -1);      // zero length
    run_op(16383, 6912, 3, 0, 1'b0, 1'b0, -1);  // address wrap
    run_op(0, 6912, 4, 0, 1'b0, 1'b1, -1);      // en held high throughout
    run_op(0, 6912, 4, 0, 1'b0, 1'b0, 2);       // reset in 3rd fetch cycle
    run_op(0, 6912, 4, 0, 1'b0, 1'b0, -1);      // clean restart -> 70

    for (int k = 0; k < 12; k++) begin
      int sh;
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      run_op(int'($urandom_range(0, MEM - 1)), int'($urandom_range(0, MEM - 1)),
             int'($urandom_range(0, 24)), sh, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
